instruction_cache_controller: RTL and testbench

//  Direct-mapped instruction cache with its refill controller. Sits between the
//  CPU fetch stage and the 128-bit block-read instruction memory (6-bit word

---
 rtl/instruction_cache_controller.sv | 128 ++++++++++++
 tb/tb_instruction_cache_controller.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_cache_controller.sv
// Direct-mapped instruction cache plus block refill FSM with hit/miss statistics.
// Ports: clock/reset; CPU side cpu_read, cpu_pc, cache_flush -> cpu_inst, cpu_busywait;
//        memory side mem_read, mem_address <- mem_readinst, mem_busywait; hit_count, miss_count.
module instruction_cache_controller #(
  parameter int LINES = 4,
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             cpu_read,
  input  logic [31:0]      cpu_pc,
  input  logic             cache_flush,
  output logic [31:0]      cpu_inst,
  output logic             cpu_busywait,
  output logic             mem_read,
  output logic [5:0]       mem_address,
  input  logic [127:0]     mem_readinst,
  input  logic             mem_busywait,
  output logic [CNT_W-1:0] hit_count,
  output logic [CNT_W-1:0] miss_count
);

  localparam int INDEX_W = $clog2(LINES);
  localparam int TAG_W   = 4 - INDEX_W;
  // With 16 lines the tag is empty; keep one constant-zero bit so the arrays stay legal.
  localparam int TAG_SW  = (TAG_W > 0) ? TAG_W : 1;

  typedef enum logic [1:0] {IDLE, MEM_REQ, MEM_WAIT, UPDATE} state_t;

  state_t state_q, state_d;

  logic [127:0]       data_q [LINES];
  logic [TAG_SW-1:0]  tag_q  [LINES];
  logic [LINES-1:0]   valid_q, valid_d;

  logic [3:0]         miss_blk_q;   // {tag,index} of the block being refilled
  logic [CNT_W-1:0]   hit_q, hit_d, miss_q, miss_d;

  // Only pc[7:2] addresses the cache; everything else aliases.
  logic [3:0]         pc_blk;
  logic [1:0]         pc_word;
  logic [INDEX_W-1:0] pc_idx, fill_idx;
  logic [TAG_SW-1:0]  pc_tag, fill_tag;
  logic [127:0]       line_data;
  logic               hit;
  logic               unused_pc;

  assign pc_blk    = cpu_pc[7:4];
  assign pc_word   = cpu_pc[3:2];
  assign pc_idx    = pc_blk[INDEX_W-1:0];
  assign pc_tag    = TAG_SW'(pc_blk >> INDEX_W);
  assign fill_idx  = miss_blk_q[INDEX_W-1:0];
  assign fill_tag  = TAG_SW'(miss_blk_q >> INDEX_W);
  assign unused_pc = ^{cpu_pc[31:8], cpu_pc[1:0]};

  assign line_data = data_q[pc_idx];
  assign hit       = cpu_read & valid_q[pc_idx] & (tag_q[pc_idx] == pc_tag);
  assign cpu_inst  = line_data[{pc_word, 5'b0} +: 32];

  assign mem_address = {miss_blk_q, 2'b00};
  assign hit_count   = hit_q;
  assign miss_count  = miss_q;

  // Next state and handshake outputs
  always_comb begin
    state_d      = state_q;
    mem_read     = 1'b0;
    cpu_busywait = 1'b1;
    case (state_q)
      IDLE: begin
        cpu_busywait = cpu_read & ~hit;
        if (cpu_read && !hit) state_d = MEM_REQ;
      end
      MEM_REQ: begin
        mem_read = 1'b1;
        if (mem_busywait) state_d = MEM_WAIT;
      end
      MEM_WAIT: begin
        if (!mem_busywait) state_d = UPDATE;
      end
      UPDATE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Valid bits: a flush clears everything, but a refill finishing in the same
  // cycle still installs its line.
  always_comb begin
    valid_d = valid_q;
    if (cache_flush) valid_d = '0;
    if (state_q == UPDATE) valid_d[fill_idx] = 1'b1;
  end

  // Saturating statistics; only IDLE cycles with an active fetch are counted.
  always_comb begin
    hit_d  = hit_q;
    miss_d = miss_q;
    if (state_q == IDLE && hit && !(&hit_q)) hit_d = hit_q + 1'b1;
    if (state_q == IDLE && cpu_read && !hit && !(&miss_q)) miss_d = miss_q + 1'b1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      valid_q    <= '0;
      miss_blk_q <= '0;
      hit_q      <= '0;
      miss_q     <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      hit_q   <= hit_d;
      miss_q  <= miss_d;
      if (state_q == IDLE && cpu_read && !hit) miss_blk_q <= pc_blk;
    end
  end

  // Line payload and tags carry no reset; the valid bit guards them.
  always_ff @(posedge clock) begin
    if (state_q == UPDATE) begin
      data_q[fill_idx] <= mem_readinst;
      tag_q[fill_idx]  <= fill_tag;
    end
  end

endmodule

// File: tb/tb_instruction_cache_controller.sv
module tb_instruction_cache_controller;

  logic         clock = 1'b0;
  logic         reset;
  logic         cpu_read;
  logic [31:0]  cpu_pc;
  logic         cache_flush;
  logic [31:0]  cpu_inst;
  logic         cpu_busywait;
  logic         mem_read;
  logic [5:0]   mem_address;
  logic [127:0] mem_readinst;
  logic         mem_busywait;
  logic [15:0]  hit_count;
  logic [15:0]  miss_count;

  int passed = 0;
  int total  = 0;

  logic [31:0] inst_q[$];
  logic [5:0]  addr_q[$];
  logic [15:0] exp_hits;
  logic [15:0] exp_misses;

  logic [5:0]  mem_addr_lat;
  bit          mem_phase;

  instruction_cache_controller #(.LINES(4), .CNT_W(16)) dut (
    .clock        (clock),
    .reset        (reset),
    .cpu_read     (cpu_read),
    .cpu_pc       (cpu_pc),
    .cache_flush  (cache_flush),
    .cpu_inst     (cpu_inst),
    .cpu_busywait (cpu_busywait),
    .mem_read     (mem_read),
    .mem_address  (mem_address),
    .mem_readinst (mem_readinst),
    .mem_busywait (mem_busywait),
    .hit_count    (hit_count),
    .miss_count   (miss_count)
  );

  always #5 clock = ~clock;

  // Memory contents: word w -> {w+1 (16 bits), 3-w[1:0] (16 bits)}
  function automatic logic [31:0] word_val(input logic [5:0] w);
    logic [5:0] w1;
    logic [1:0] lo;
    w1 = w + 6'd1;
    lo = 2'd3 - w[1:0];
    return {10'd0, w1, 14'd0, lo};
  endfunction

  function automatic logic [127:0] block_val(input logic [5:0] a);
    logic [127:0] b;
    for (int i = 0; i < 4; i++) b[32*i +: 32] = word_val(6'(a + i));
    return b;
  endfunction

  // Memory model: busy rises in the cycle after mem_read is seen, stays high
  // one more cycle, then drops with the block on the bus.
  always @(negedge clock or posedge reset) begin
    if (reset) begin
      mem_busywait = 1'b0;
      mem_phase    = 1'b0;
    end else if (mem_busywait) begin
      if (!mem_phase) mem_phase = 1'b1;
      else begin
        mem_busywait = 1'b0;
        mem_readinst = block_val(mem_addr_lat);
      end
    end else if (mem_read) begin
      mem_busywait = 1'b1;
      mem_phase    = 1'b0;
      mem_addr_lat = mem_address;
    end
  end

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // One fetch: push expectations, wait until served, compare against the queues.
  // A miss stalls for the miss cycle itself plus MEM_REQ, MEM_WAIT x2, UPDATE.
  task automatic fetch(input logic [31:0] pc, input bit exp_miss, input string name);
    int  busy;
    bit  done;
    bit  addr_seen;
    logic [31:0] exp_inst;
    logic [5:0]  exp_addr;
    @(posedge clock); #1;
    cpu_read = 1'b1;
    cpu_pc   = pc;
    inst_q.push_back(word_val(pc[7:2]));
    if (exp_miss) addr_q.push_back({pc[7:4], 2'b00});
    busy = 0; done = 0; addr_seen = 0;
    for (int c = 0; c < 30 && !done; c++) begin
      @(negedge clock);
      if (mem_read && !addr_seen) begin
        addr_seen = 1;
        total++;
        if (addr_q.size() == 0) begin
          $display("FAIL %s unexpected mem_read: addr=%h required none", name, mem_address);
        end else begin
          exp_addr = addr_q.pop_front();
          if (mem_address !== exp_addr)
            $display("FAIL %s mem_address: got %h required %h", name, mem_address, exp_addr);
          else passed++;
        end
      end
      if (cpu_busywait) busy++;
      else begin
        done = 1;
        exp_inst = inst_q.pop_front();
        total++;
        if (cpu_inst !== exp_inst)
          $display("FAIL %s cpu_inst: got %h required %h", name, cpu_inst, exp_inst);
        else passed++;
        total++;
        if (busy !== (exp_miss ? 5 : 0))
          $display("FAIL %s stall cycles: got %0d required %0d", name, busy, exp_miss ? 5 : 0);
        else passed++;
      end
    end
    if (!done) begin
      total++;
      $display("FAIL %s timeout: busywait still %b required 0", name, cpu_busywait);
      inst_q.delete();
    end
    if (exp_miss && !addr_seen) begin
      total++;
      $display("FAIL %s mem_read never seen: got 0 required 1", name);
      addr_q.delete();
    end
    if (done) begin
      exp_hits = sat_inc(exp_hits);
      if (exp_miss) exp_misses = sat_inc(exp_misses);
    end
  endtask

  // Let the serve cycle's counter update land, then drop the request.
  task automatic end_fetch_and_check_counters(input string name);
    @(posedge clock); #1;
    cpu_read = 1'b0;
    total++;
    if (hit_count !== exp_hits)
      $display("FAIL %s hit_count: got %h required %h", name, hit_count, exp_hits);
    else passed++;
    total++;
    if (miss_count !== exp_misses)
      $display("FAIL %s miss_count: got %h required %h", name, miss_count, exp_misses);
    else passed++;
  endtask

  task automatic test_reset();
    reset = 1'b1; cpu_read = 1'b0; cpu_pc = '0; cache_flush = 1'b0;
    mem_readinst = '0; mem_addr_lat = '0;
    exp_hits = '0; exp_misses = '0;
    repeat (2) @(negedge clock);
    total++; if (mem_read !== 1'b0) $display("FAIL reset mem_read: got %b required 0", mem_read); else passed++;
    total++; if (mem_address !== 6'd0) $display("FAIL reset mem_address: got %h required 00", mem_address); else passed++;
    total++; if (cpu_busywait !== 1'b0) $display("FAIL reset cpu_busywait: got %b required 0", cpu_busywait); else passed++;
    total++; if (hit_count !== 16'd0) $display("FAIL reset hit_count: got %h required 0", hit_count); else passed++;
    total++; if (miss_count !== 16'd0) $display("FAIL reset miss_count: got %h required 0", miss_count); else passed++;
    @(posedge clock); #1;
    reset = 1'b0;
  endtask

  task automatic test_cold_miss();
    fetch(32'h00, 1'b1, "cold_0x00");
    end_fetch_and_check_counters("cold");
  endtask

  task automatic test_back_to_back();
    fetch(32'h04, 1'b0, "seq_0x04");
    fetch(32'h08, 1'b0, "seq_0x08");
    fetch(32'h0C, 1'b0, "seq_0x0C");
    fetch(32'hFFFF_FF07, 1'b0, "alias_0xFFFFFF07");
    end_fetch_and_check_counters("seq");
  endtask

  task automatic test_conflict();
    fetch(32'h40, 1'b1, "conflict_0x40");
    fetch(32'h00, 1'b1, "conflict_0x00");
    end_fetch_and_check_counters("conflict");
  endtask

  task automatic test_flush();
    @(posedge clock); #1; cache_flush = 1'b1;
    @(posedge clock); #1; cache_flush = 1'b0;
    fetch(32'h04, 1'b1, "flush_0x04");
    end_fetch_and_check_counters("flush");
  endtask

  task automatic test_reset_mid_refill();
    bit reached;
    @(posedge clock); #1;
    cpu_read = 1'b1; cpu_pc = 32'h20;
    reached = 0;
    for (int c = 0; c < 10 && !reached; c++) begin
      @(negedge clock);
      if (mem_read) reached = 1;
    end
    total++;
    if (!reached) $display("FAIL midreset mem_read never seen: got 0 required 1");
    else passed++;
    @(posedge clock); #1;           // now in MEM_WAIT
    reset = 1'b1; cpu_read = 1'b0;
    exp_hits = '0; exp_misses = '0;
    #1;
    total++; if (mem_read !== 1'b0) $display("FAIL midreset mem_read: got %b required 0", mem_read); else passed++;
    total++; if (cpu_busywait !== 1'b0) $display("FAIL midreset cpu_busywait: got %b required 0", cpu_busywait); else passed++;
    total++; if (hit_count !== 16'd0) $display("FAIL midreset hit_count: got %h required 0", hit_count); else passed++;
    total++; if (miss_count !== 16'd0) $display("FAIL midreset miss_count: got %h required 0", miss_count); else passed++;
    @(posedge clock); #1;
    reset = 1'b0;
    fetch(32'h20, 1'b1, "postreset_0x20");
    end_fetch_and_check_counters("postreset");
  endtask

  task automatic test_saturation();
    @(posedge clock); #1;
    force dut.hit_q = 16'hFFFE;
    @(posedge clock); #1;
    release dut.hit_q;
    exp_hits = 16'hFFFE;
    fetch(32'h20, 1'b0, "sat_1");
    fetch(32'h24, 1'b0, "sat_2");
    fetch(32'h28, 1'b0, "sat_3");
    end_fetch_and_check_counters("sat");
  endtask

  initial begin
    test_reset();
    test_cold_miss();
    test_back_to_back();
    test_conflict();
    test_flush();
    test_reset_mid_refill();
    test_saturation();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
